etapa_busqueda: RTL

Instruction-fetch stage of the MIPS datapath. Holds the program counter, drives the byte address into `MemoriaDeInstrucciones` (`dir`) and captures its combinational output (`salidaMemoriaDeInstrucciones`) into the IF/ID pipeline register, together with PC and PC+4. It applies stall, flush and branch/jump redirect requests coming from the decode stage.

---
 rtl/etapa_busqueda_pkg.sv | 21 ++
 rtl/etapa_busqueda_if.sv | 25 ++
 rtl/etapa_busqueda_contador_programa.sv | 46 ++++
 rtl/etapa_busqueda.sv | 101 ++++++++++
 4 files changed

// File: rtl/etapa_busqueda_pkg.sv
// Shared fetch-stage definitions: instruction width, PC increment, reset PC and bubble encoding.
// Decode and hazard logic import the same constants so that all stages agree on them.
package etapa_busqueda_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [31:0] NOP_DEF      = 32'h0000_0000;

    // Word-aligned PC successor; wraps modulo 2^32.
    function automatic logic [31:0] pc_siguiente(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

    // Forces a byte address onto a word boundary.
    function automatic logic [31:0] alinear(input logic [31:0] dir);
        return dir & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/etapa_busqueda_if.sv
// Fetch-stage bundle: instruction memory port, decode-stage control and the IF/ID register outputs.
interface etapa_busqueda_if;
    import etapa_busqueda_pkg::*;

    logic [31:0]        dir;
    logic [INSTR_W-1:0] instr_mem;
    logic               stall;
    logic               flush;
    logic               salto_valido;
    logic [31:0]        destino_salto;
    logic [INSTR_W-1:0] if_id_instr;
    logic [31:0]        if_id_pc;
    logic [31:0]        if_id_pc4;
    logic               if_id_valido;

    modport master (
        output dir, if_id_instr, if_id_pc, if_id_pc4, if_id_valido,
        input  instr_mem, stall, flush, salto_valido, destino_salto
    );

    modport slave (
        input  dir, if_id_instr, if_id_pc, if_id_pc4, if_id_valido,
        output instr_mem, stall, flush, salto_valido, destino_salto
    );
endinterface

// File: rtl/etapa_busqueda_contador_programa.sv
// Program counter: PC register, +4 adder and next-PC selection (redirect > stall > increment).
module contador_programa
    import etapa_busqueda_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        salto_valido,
    input  logic [31:0] destino_salto,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    logic [31:0] pc_r;
    logic [31:0] pc_sig_s;
    logic [31:0] pc4_s;

    assign pc4_s = pc_siguiente(pc_r);

    // Next-PC selection; flush does not affect the PC.
    always_comb begin
        pc_sig_s = pc4_s;
        if (salto_valido) begin
            pc_sig_s = alinear(destino_salto);
        end else if (stall) begin
            pc_sig_s = pc_r;
        end else begin
            pc_sig_s = pc4_s;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= alinear(RESET_PC);
        end else begin
            pc_r <= pc_sig_s;
        end
    end

    assign pc  = pc_r;
    assign pc4 = pc4_s;

endmodule

// File: rtl/etapa_busqueda.sv
// MIPS instruction-fetch stage: PC, instruction memory address and IF/ID pipeline register.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect flag (error_alineacion).
module etapa_busqueda
    import etapa_busqueda_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    etapa_busqueda_if.master   bus
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               error_alineacion
`endif
);

    logic [31:0]        pc_s;
    logic [31:0]        pc4_s;
    logic [INSTR_W-1:0] instr_r;
    logic [31:0]        ifid_pc_r;
    logic [31:0]        ifid_pc4_r;
    logic               valido_r;
    logic [INSTR_W-1:0] instr_sig_s;
    logic [31:0]        ifid_pc_sig_s;
    logic [31:0]        ifid_pc4_sig_s;
    logic               valido_sig_s;

    contador_programa #(.RESET_PC(RESET_PC)) u_pc (
        .clk           (clk),
        .reset         (reset),
        .salto_valido  (bus.salto_valido),
        .destino_salto (bus.destino_salto),
        .stall         (bus.stall),
        .pc            (pc_s),
        .pc4           (pc4_s)
    );

    // IF/ID next value: the IF instruction is wrong-path on redirect, so it becomes a bubble.
    always_comb begin
        instr_sig_s    = bus.instr_mem;
        ifid_pc_sig_s  = pc_s;
        ifid_pc4_sig_s = pc4_s;
        valido_sig_s   = 1'b1;
        if (bus.salto_valido || (!bus.stall && bus.flush)) begin
            instr_sig_s    = NOP_INSTR;
            ifid_pc_sig_s  = 32'h0000_0000;
            ifid_pc4_sig_s = 32'h0000_0000;
            valido_sig_s   = 1'b0;
        end else if (bus.stall) begin
            instr_sig_s    = instr_r;
            ifid_pc_sig_s  = ifid_pc_r;
            ifid_pc4_sig_s = ifid_pc4_r;
            valido_sig_s   = valido_r;
        end else begin
            instr_sig_s    = bus.instr_mem;
            ifid_pc_sig_s  = pc_s;
            ifid_pc4_sig_s = pc4_s;
            valido_sig_s   = 1'b1;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r    <= NOP_INSTR;
            ifid_pc_r  <= 32'h0000_0000;
            ifid_pc4_r <= 32'h0000_0000;
            valido_r   <= 1'b0;
        end else begin
            instr_r    <= instr_sig_s;
            ifid_pc_r  <= ifid_pc_sig_s;
            ifid_pc4_r <= ifid_pc4_sig_s;
            valido_r   <= valido_sig_s;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic error_r;

    // Sticky flag for redirects whose target is not word aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_r <= 1'b0;
        end else if (bus.salto_valido && (bus.destino_salto[1:0] != 2'b00)) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign error_alineacion = error_r;
`endif

    assign bus.dir          = pc_s;
    assign bus.if_id_instr  = instr_r;
    assign bus.if_id_pc     = ifid_pc_r;
    assign bus.if_id_pc4    = ifid_pc4_r;
    assign bus.if_id_valido = valido_r;

endmodule
